// File: rtl/reg_sampler_pkg.sv
// Shared widths and sampler state type for the register sampling read port.
// REG_SAMPLER_CSUM_EN adds the CSUM state used for the trailing checksum byte.
package reg_sampler_pkg;

  localparam int RegNum     = 16;
  localparam int RegWidth   = 16;
  localparam int RegNumLog2 = 4;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

`ifdef REG_SAMPLER_CSUM_EN
  typedef enum logic [2:0] {IDLE, READ, SEND, CSUM, FIN} sampler_state_t;
`else
  typedef enum logic [2:0] {IDLE, READ, SEND, FIN} sampler_state_t;
`endif

endpackage

// File: rtl/reg_sampler_if.sv
// Control, regfile sampling port and byte-stream link of the register sampler.
// master = sampler side, slave = regfile/UART/host side.
interface reg_sampler_if #(
  parameter int ADDR_W = reg_sampler_pkg::RegNumLog2,
  parameter int REG_W  = reg_sampler_pkg::RegWidth
) ();

  logic              start;
  logic              busy;
  logic              done;
  logic              rse;
  logic [ADDR_W-1:0] rsaddr;
  logic [REG_W-1:0]  rsdata;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    input  start, rsdata, tx_ready,
    output busy, done, rse, rsaddr, tx_data, tx_valid
  );

  modport slave (
    output start, rsdata, tx_ready,
    input  busy, done, rse, rsaddr, tx_data, tx_valid
  );

endinterface

// File: rtl/reg_sampler.sv
// Snapshots R0..R(REG_NUM-1) through the sampling read port and streams the values
// MSB byte first over valid/ready. REG_SAMPLER_CSUM_EN appends an XOR checksum byte.
//
// state | meaning
// IDLE  | waiting for start
// READ  | rse asserted for one cycle, register value captured into shadow
// SEND  | presenting shadow bytes, MSB first, until all accepted
// CSUM  | presenting the XOR of all frame bytes (REG_SAMPLER_CSUM_EN only)
// FIN   | one-cycle done pulse
module reg_sampler
  import reg_sampler_pkg::*;
#(
  parameter int REG_NUM = RegNum,
  parameter int REG_W   = RegWidth,
  parameter int ADDR_W  = RegNumLog2
) (
  input logic           clk,
  input logic           rst,
  reg_sampler_if.master bus
);

  localparam int                BYTES    = REG_W / 8;
  localparam int                BC_W     = cnt_width(BYTES);
  localparam logic [BC_W-1:0]   BC_LAST  = BC_W'(BYTES - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(REG_NUM - 1);

  sampler_state_t    state, state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [BC_W-1:0]   byte_cnt;
  logic [REG_W-1:0]  shadow;
  logic [7:0]        byte_sel;
  logic              hs;
`ifdef REG_SAMPLER_CSUM_EN
  logic [7:0]        csum;
`endif

  assign byte_sel = shadow[{byte_cnt, 3'b000} +: 8];
  assign hs       = bus.tx_valid && bus.tx_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    bus.rse      = 1'b0;
    bus.rsaddr   = '0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = READ;
      end
      READ: begin
        bus.busy   = 1'b1;
        bus.rse    = 1'b1;
        bus.rsaddr = idx;
        state_nxt  = SEND;
      end
      SEND: begin
        bus.busy     = 1'b1;
        bus.tx_valid = 1'b1;
        bus.tx_data  = byte_sel;
        if (bus.tx_ready && byte_cnt == '0) begin
          if (idx == IDX_LAST) begin
`ifdef REG_SAMPLER_CSUM_EN
            state_nxt = CSUM;
`else
            state_nxt = FIN;
`endif
          end else begin
            state_nxt = READ;
          end
        end
      end
`ifdef REG_SAMPLER_CSUM_EN
      CSUM: begin
        bus.busy     = 1'b1;
        bus.tx_valid = 1'b1;
        bus.tx_data  = csum;
        if (bus.tx_ready) state_nxt = FIN;
      end
`endif
      FIN: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      byte_cnt <= '0;
      shadow   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) idx <= '0;
        READ: begin
          shadow   <= bus.rsdata;
          byte_cnt <= BC_LAST;
        end
        SEND: if (hs) begin
          if (byte_cnt != '0)      byte_cnt <= byte_cnt - 1'b1;
          else if (idx != IDX_LAST) idx      <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef REG_SAMPLER_CSUM_EN
  // Checksum covers register bytes only; the checksum byte itself is not folded in.
  always_ff @(posedge clk) begin
    if (rst)                           csum <= 8'h00;
    else if (state == IDLE && bus.start) csum <= 8'h00;
    else if (state == SEND && hs)      csum <= csum ^ byte_sel;
  end
`endif

endmodule

// File: tb/tb_reg_sampler.sv
// Scoreboard bench for reg_sampler: a regfile model drives rsdata, frames are
// predicted from the register contents at start, and a monitor checks the byte stream.
module tb_reg_sampler;
  import reg_sampler_pkg::*;

`ifdef REG_SAMPLER_CSUM_EN
  localparam int FRAME_CYC = 50;
`else
  localparam int FRAME_CYC = 49;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_sampler_if bus ();

  reg_sampler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] regs [16];
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        bp_en;

  logic [7:0] exp_q[$];
  int errors = 0, checks = 0;
  int seen = 0, done_seen = 0, done_cyc = 0, exp_done = 0, cyc = 0, t0 = 0;
  logic       hold_pend = 1'b0;
  logic [7:0] hold_data = 8'h00;
  logic [3:0] exp_addr = 4'd0;

  // Regfile model: R0 reads zero, same-cycle write bypasses to the read port.
  always_comb begin
    if (bus.rsaddr == 4'd0)                      bus.rsdata = 16'h0000;
    else if (wr_en && wr_addr == bus.rsaddr)     bus.rsdata = wr_data;
    else                                         bus.rsdata = regs[bus.rsaddr];
  end

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    bus.tx_ready = bp_en ? ($urandom_range(0, 9) >= 3) : 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
      exp_addr  = 4'd0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", {31'd0, bus.tx_valid}, 32'd1);
        chk("hold_data", {24'd0, bus.tx_data}, {24'd0, hold_data});
      end
      if (bus.rse) begin
        chk("rsaddr", {28'd0, bus.rsaddr}, {28'd0, exp_addr});
        exp_addr = exp_addr + 4'd1;
      end
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_q.size() == 0) chk("unexpected_byte", {24'd0, bus.tx_data}, 32'hFFFF_FFFF);
        else                   chk("byte", {24'd0, bus.tx_data}, {24'd0, exp_q.pop_front()});
        seen++;
      end
      hold_pend = bus.tx_valid && !bus.tx_ready;
      hold_data = bus.tx_data;
      if (bus.done) begin
        done_seen++;
        done_cyc = cyc;
        exp_addr = 4'd0;
        chk("busy_at_done", {31'd0, bus.busy}, 32'd0);
        chk("frame_len", exp_q.size(), 32'd0);
      end
    end
  end

  task automatic push_frame(input bit ovr3);
    logic [15:0] v;
    logic [7:0]  x;
    x = 8'h00;
    for (int k = 0; k < 16; k++) begin
      v = (k == 0) ? 16'h0000 : regs[k];
      if (ovr3 && k == 3) v = 16'hBEEF;
      exp_q.push_back(v[15:8]);
      exp_q.push_back(v[7:0]);
      x = x ^ v[15:8] ^ v[7:0];
    end
`ifdef REG_SAMPLER_CSUM_EN
    exp_q.push_back(x);
`endif
    exp_done++;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    bus.start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 3000 && done_seen < target; i++) @(posedge clk);
    chk("done_wait", {31'd0, done_seen >= target}, 32'd1);
    @(posedge clk); #1;
    chk("busy_after", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic wait_bytes(input int target);
    for (int i = 0; i < 3000 && seen < target; i++) @(posedge clk);
    chk("byte_wait", {31'd0, seen >= target}, 32'd1);
  endtask

  task automatic load_pattern();
    regs[0] = 16'h1100;
    for (int k = 1; k < 16; k++) regs[k] = 16'h1100 + 16'(k);
  endtask

  task automatic load_random();
    for (int k = 0; k < 16; k++) regs[k] = 16'($urandom);
  endtask

  initial begin
    rst = 1'b1; bus.start = 1'b0; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 16'h0; bp_en = 1'b0;
    load_pattern();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_rse", {31'd0, bus.rse}, 32'd0);
    chk("rst_rsaddr", {28'd0, bus.rsaddr}, 32'd0);
    chk("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    chk("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
    rst = 1'b0;

    // known pattern, no back-pressure, exact timing
    push_frame(1'b0);
    pulse_start();
    wait_done(exp_done);
    chk("done_cycle", done_cyc - t0, FRAME_CYC);

    // random data under back-pressure
    bp_en = 1'b1;
    for (int f = 0; f < 3; f++) begin
      load_random();
      push_frame(1'b0);
      pulse_start();
      wait_done(exp_done);
    end
    bp_en = 1'b0;

    // start during busy is dropped
    load_random();
    push_frame(1'b0);
    pulse_start();
    wait_bytes(seen + 4);
    pulse_start();
    wait_done(exp_done);
    repeat (60) @(posedge clk);
    chk("single_done", done_seen, exp_done);

    // same-cycle write bypass on R3
    load_random();
    push_frame(1'b1);
    pulse_start();
    for (int i = 0; i < 200 && !(bus.rse && bus.rsaddr == 4'd3); i++) @(negedge clk);
    chk("r3_seen", {31'd0, bus.rse && bus.rsaddr == 4'd3}, 32'd1);
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hBEEF;
    @(posedge clk); #1;
    regs[3] = 16'hBEEF;
    wr_en = 1'b0;
    wait_done(exp_done);

    // reset mid-frame aborts; next frame is clean
    bp_en = 1'b1;
    load_random();
    push_frame(1'b0);
    pulse_start();
    wait_bytes(seen + 10);
    #1;
    rst = 1'b1;
    exp_q.delete();
    exp_done--;
    @(posedge clk); #1;
    chk("abort_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
    chk("abort_rse", {31'd0, bus.rse}, 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    load_random();
    push_frame(1'b0);
    pulse_start();
    wait_done(exp_done);
    bp_en = 1'b0;

    // pattern again: checksum byte when enabled, exactly 32 bytes otherwise
    load_pattern();
    push_frame(1'b0);
    pulse_start();
    wait_done(exp_done);
    chk("done_cycle2", done_cyc - t0, FRAME_CYC);
    repeat (40) @(posedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    chk("done_count", done_seen, exp_done);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
